// File: rtl/flag_status_unit_if.sv
// -----------------------------------------------------------------------------
// flag_status_unit_if
//
// Purpose: groups the ALU-flag, stack-control and branch-condition signals
// that pass between the datapath/control unit and flag_status_unit.
//
// Signals:
//   alu_flags    [3:0]          flags from the ALU {N,V,C,Z}
//   flags_en                    load alu_flags into the status register
//   flags_push                  save the status register onto the stack
//   flags_pop                   restore the status register from the stack top
//   err_clear                   clear the sticky stack error
//   cond_code    [3:0]          branch condition selector
//   cond_valid                  evaluate cond_code this cycle
//   flags        [3:0]          registered status flags
//   branch_valid                one-cycle pulse, branch_taken is meaningful
//   branch_taken                registered condition result
//   stack_depth  [DEPTH_W-1:0]  number of occupied stack entries
//   stack_err                   sticky overflow/underflow/conflict error
//
// Modports:
//   master - the driving side (ALU / control unit)
//   slave  - flag_status_unit
//
// Handshake: cond_valid -> branch_valid is a valid-only pipe with no ready.
// Every cycle with cond_valid high at a rising edge yields exactly one
// branch_valid pulse after that edge; the consumer must accept it then.
// -----------------------------------------------------------------------------
interface flag_status_unit_if #(
    parameter int DEPTH_W = 3
);
    logic [3:0]         alu_flags;
    logic               flags_en;
    logic               flags_push;
    logic               flags_pop;
    logic               err_clear;
    logic [3:0]         cond_code;
    logic               cond_valid;
    logic [3:0]         flags;
    logic               branch_valid;
    logic               branch_taken;
    logic [DEPTH_W-1:0] stack_depth;
    logic               stack_err;

    modport master (
        output alu_flags, flags_en, flags_push, flags_pop, err_clear,
               cond_code, cond_valid,
        input  flags, branch_valid, branch_taken, stack_depth, stack_err
    );

    modport slave (
        input  alu_flags, flags_en, flags_push, flags_pop, err_clear,
               cond_code, cond_valid,
        output flags, branch_valid, branch_taken, stack_depth, stack_err
    );
endinterface

// File: rtl/flag_status_unit.sv
// -----------------------------------------------------------------------------
// flag_status_unit
//
// Purpose: processor status register for the ALU flags {N,V,C,Z}, a branch
// condition evaluator with a registered taken/not-taken result, and a small
// LIFO used to save/restore the flags across interrupt entry and return.
//
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - flag_status_unit_if.slave (see the interface for signal list);
//          the interface DEPTH_W must match this module's DEPTH_W.
//
// Parameters:
//   STACK_DEPTH - number of flag save entries (>= 1)
//   DEPTH_W     - width of stack_depth
// -----------------------------------------------------------------------------
module flag_status_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    flag_status_unit_if.slave bus
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FULL_LVL = DEPTH_W'(STACK_DEPTH);

    logic [3:0]         flags_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               err_q;
    logic               bvalid_q;
    logic               btaken_q;
    logic [3:0]         stack_mem [STACK_DEPTH];

    logic               push_req;
    logic               pop_req;
    logic               both_req;
    logic               full;
    logic               empty;
    logic               push_ok;
    logic               pop_ok;
    logic               err_now;
    logic [DEPTH_W-1:0] depth_m1;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic [3:0]         flags_next;
    logic               cond_result;

    // Flag condition lookup; f is {N,V,C,Z}.
    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic z, c, v, n;
        z = f[0];
        c = f[1];
        v = f[2];
        n = f[3];
        case (code)
            4'd0:    eval_cond = z;
            4'd1:    eval_cond = !z;
            4'd2:    eval_cond = c;
            4'd3:    eval_cond = !c;
            4'd4:    eval_cond = n;
            4'd5:    eval_cond = !n;
            4'd6:    eval_cond = v;
            4'd7:    eval_cond = !v;
            4'd8:    eval_cond = c & !z;
            4'd9:    eval_cond = !c | z;
            4'd10:   eval_cond = (n == v);
            4'd11:   eval_cond = (n != v);
            4'd12:   eval_cond = !z & (n == v);
            4'd13:   eval_cond = z | (n != v);
            4'd14:   eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    always_comb begin
        push_req = bus.flags_push & ~bus.flags_pop;
        pop_req  = bus.flags_pop & ~bus.flags_push;
        both_req = bus.flags_push & bus.flags_pop;
        full     = (depth_q == FULL_LVL);
        empty    = (depth_q == '0);
        push_ok  = push_req & ~full;
        pop_ok   = pop_req & ~empty;
        err_now  = (push_req & full) | (pop_req & empty) | both_req;

        // Index slices are only used when the matching push/pop is legal,
        // so the truncation of depth to IDX_W bits never aliases.
        depth_m1 = depth_q - DEPTH_W'(1);
        wr_idx   = depth_q[IDX_W-1:0];
        rd_idx   = depth_m1[IDX_W-1:0];

        // Pop beats FlagsEn; an illegal pop/push leaves FlagsEn in charge.
        if (pop_ok) begin
            flags_next = stack_mem[rd_idx];
        end else if (bus.flags_en) begin
            flags_next = bus.alu_flags;
        end else begin
            flags_next = flags_q;
        end

        // Evaluate against the forwarded value so a same-cycle compare and
        // branch sees the fresh flags.
        cond_result = eval_cond(bus.cond_code, flags_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q  <= '0;
            depth_q  <= '0;
            err_q    <= 1'b0;
            bvalid_q <= 1'b0;
            btaken_q <= 1'b0;
        end else begin
            flags_q  <= flags_next;
            bvalid_q <= bus.cond_valid;
            if (bus.cond_valid) begin
                btaken_q <= cond_result;
            end
            if (push_ok) begin
                depth_q <= depth_q + DEPTH_W'(1);
            end else if (pop_ok) begin
                depth_q <= depth_m1;
            end
            // A new error in the same cycle wins over err_clear.
            if (err_now) begin
                err_q <= 1'b1;
            end else if (bus.err_clear) begin
                err_q <= 1'b0;
            end
        end
    end

    // Stack contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[wr_idx] <= flags_q;
        end
    end

    assign bus.flags        = flags_q;
    assign bus.branch_valid = bvalid_q;
    assign bus.branch_taken = btaken_q;
    assign bus.stack_depth  = depth_q;
    assign bus.stack_err    = err_q;

endmodule

// File: tb/tb_flag_status_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_status_unit
//
// Purpose: directed self-checking bench for flag_status_unit (STACK_DEPTH=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_flag_status_unit;

    localparam int STACK_DEPTH = 4;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

    logic clk;
    logic rst;
    int   total;
    int   bad;

    flag_status_unit_if #(.DEPTH_W(DEPTH_W)) bus ();

    flag_status_unit #(
        .STACK_DEPTH(STACK_DEPTH),
        .DEPTH_W    (DEPTH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alu_flags  = 4'h0;
        bus.flags_en   = 1'b0;
        bus.flags_push = 1'b0;
        bus.flags_pop  = 1'b0;
        bus.err_clear  = 1'b0;
        bus.cond_code  = 4'h0;
        bus.cond_valid = 1'b0;
    endtask

    task automatic load_flags(input logic [3:0] v);
        bus.flags_en  = 1'b1;
        bus.alu_flags = v;
        step();
        bus.flags_en  = 1'b0;
    endtask

    // Expected taken bits per condition code (bit i = code i).
    // flags 0011 (C,Z): 16'h66A5 ; flags 0010 (C only): 16'h55A6
    logic [3:0]  tbl_flags [2];
    logic [15:0] tbl_exp   [2];

    initial begin
        total = 0;
        bad   = 0;
        tbl_flags[0] = 4'b0011;
        tbl_exp[0]   = 16'h66A5;
        tbl_flags[1] = 4'b0010;
        tbl_exp[1]   = 16'h55A6;

        // ---------------- reset ----------------
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk("rst_flags", 8'(bus.flags), 8'h0);
        chk("rst_depth", 8'(bus.stack_depth), 8'h0);
        chk("rst_bvalid", 8'(bus.branch_valid), 8'h0);
        chk("rst_btaken", 8'(bus.branch_taken), 8'h0);
        chk("rst_err", 8'(bus.stack_err), 8'h0);
        rst = 1'b0;
        step();

        // ---------------- load + EQ same cycle ----------------
        bus.flags_en   = 1'b1;
        bus.alu_flags  = 4'b0001;
        bus.cond_valid = 1'b1;
        bus.cond_code  = 4'd0;
        step();
        chk("fwd_flags", 8'(bus.flags), 8'h1);
        chk("fwd_bvalid", 8'(bus.branch_valid), 8'h1);
        chk("fwd_eq_taken", 8'(bus.branch_taken), 8'h1);
        bus.flags_en  = 1'b0;
        bus.cond_code = 4'd1;
        step();
        chk("ne_bvalid", 8'(bus.branch_valid), 8'h1);
        chk("ne_taken", 8'(bus.branch_taken), 8'h0);
        bus.cond_valid = 1'b0;

        // ---------------- signed compares, N only ----------------
        load_flags(4'b1000);
        bus.cond_valid = 1'b1;
        bus.cond_code = 4'd10; step();
        chk("ge_bvalid", 8'(bus.branch_valid), 8'h1);
        chk("ge_taken", 8'(bus.branch_taken), 8'h0);
        bus.cond_code = 4'd11; step();
        chk("lt_bvalid", 8'(bus.branch_valid), 8'h1);
        chk("lt_taken", 8'(bus.branch_taken), 8'h1);
        bus.cond_code = 4'd12; step();
        chk("gt_bvalid", 8'(bus.branch_valid), 8'h1);
        chk("gt_taken", 8'(bus.branch_taken), 8'h0);
        bus.cond_code = 4'd13; step();
        chk("le_bvalid", 8'(bus.branch_valid), 8'h1);
        chk("le_taken", 8'(bus.branch_taken), 8'h1);
        bus.cond_valid = 1'b0;
        bus.cond_code  = 4'd15;
        step();
        chk("idle_bvalid", 8'(bus.branch_valid), 8'h0);
        chk("idle_btaken_hold", 8'(bus.branch_taken), 8'h1);

        // ---------------- full condition table sweeps ----------------
        for (int t = 0; t < 2; t++) begin
            logic [15:0] ev;
            ev = tbl_exp[t];
            load_flags(tbl_flags[t]);
            bus.cond_valid = 1'b1;
            for (int c = 0; c < 16; c++) begin
                bus.cond_code = 4'(c);
                step();
                chk($sformatf("tbl%0d_cc%0d_bvalid", t, c), 8'(bus.branch_valid), 8'h1);
                chk($sformatf("tbl%0d_cc%0d_taken", t, c), 8'(bus.branch_taken), 8'(ev[c]));
            end
            bus.cond_valid = 1'b0;
        end

        // ---------------- fill the stack ----------------
        for (int v = 1; v <= 4; v++) begin
            load_flags(4'(v));
            bus.flags_push = 1'b1;
            step();
            bus.flags_push = 1'b0;
            chk($sformatf("push%0d_depth", v), 8'(bus.stack_depth), 8'(v));
            chk($sformatf("push%0d_err", v), 8'(bus.stack_err), 8'h0);
        end
        bus.flags_push = 1'b1;
        step();
        bus.flags_push = 1'b0;
        chk("overflow_depth", 8'(bus.stack_depth), 8'h4);
        chk("overflow_err", 8'(bus.stack_err), 8'h1);
        bus.err_clear = 1'b1;
        step();
        bus.err_clear = 1'b0;
        chk("overflow_clear", 8'(bus.stack_err), 8'h0);

        // ---------------- drain the stack ----------------
        for (int v = 4; v >= 1; v--) begin
            bus.flags_pop = 1'b1;
            step();
            bus.flags_pop = 1'b0;
            chk($sformatf("pop%0d_flags", v), 8'(bus.flags), 8'(v));
            chk($sformatf("pop%0d_depth", v), 8'(bus.stack_depth), 8'(v - 1));
        end

        // ---------------- underflow with FlagsEn ----------------
        bus.flags_pop = 1'b1;
        bus.flags_en  = 1'b1;
        bus.alu_flags = 4'b0110;
        step();
        bus.flags_pop = 1'b0;
        bus.flags_en  = 1'b0;
        chk("underflow_flags", 8'(bus.flags), 8'h6);
        chk("underflow_err", 8'(bus.stack_err), 8'h1);
        chk("underflow_depth", 8'(bus.stack_depth), 8'h0);
        bus.err_clear = 1'b1;
        step();
        bus.err_clear = 1'b0;
        chk("underflow_clear", 8'(bus.stack_err), 8'h0);

        // ---------------- push+pop conflict, new error beats clear ----------------
        bus.flags_push = 1'b1;
        bus.flags_pop  = 1'b1;
        bus.err_clear  = 1'b1;
        bus.flags_en   = 1'b1;
        bus.alu_flags  = 4'b1001;
        step();
        idle_inputs();
        chk("conflict_err", 8'(bus.stack_err), 8'h1);
        chk("conflict_depth", 8'(bus.stack_depth), 8'h0);
        chk("conflict_flags", 8'(bus.flags), 8'h9);
        bus.err_clear = 1'b1;
        step();
        bus.err_clear = 1'b0;
        chk("conflict_clear", 8'(bus.stack_err), 8'h0);

        // ---------------- push with same-cycle FlagsEn ----------------
        load_flags(4'b0010);
        bus.flags_push = 1'b1;
        bus.flags_en   = 1'b1;
        bus.alu_flags  = 4'b0111;
        step();
        idle_inputs();
        chk("pushen_flags", 8'(bus.flags), 8'h7);
        chk("pushen_depth", 8'(bus.stack_depth), 8'h1);

        // ---------------- pop beats FlagsEn and is forwarded ----------------
        bus.flags_pop  = 1'b1;
        bus.flags_en   = 1'b1;
        bus.alu_flags  = 4'b1111;
        bus.cond_valid = 1'b1;
        bus.cond_code  = 4'd2;
        step();
        idle_inputs();
        chk("popfwd_flags", 8'(bus.flags), 8'h2);
        chk("popfwd_bvalid", 8'(bus.branch_valid), 8'h1);
        chk("popfwd_taken", 8'(bus.branch_taken), 8'h1);
        chk("popfwd_depth", 8'(bus.stack_depth), 8'h0);

        // ---------------- asynchronous reset mid-sequence ----------------
        load_flags(4'b0101);
        bus.flags_push = 1'b1;
        step();
        step();
        bus.flags_push = 1'b0;
        bus.cond_valid = 1'b1;
        bus.cond_code  = 4'd14;
        step();
        idle_inputs();
        chk("pre_arst_depth", 8'(bus.stack_depth), 8'h2);
        chk("pre_arst_bvalid", 8'(bus.branch_valid), 8'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_flags", 8'(bus.flags), 8'h0);
        chk("arst_depth", 8'(bus.stack_depth), 8'h0);
        chk("arst_bvalid", 8'(bus.branch_valid), 8'h0);
        chk("arst_btaken", 8'(bus.branch_taken), 8'h0);
        chk("arst_err", 8'(bus.stack_err), 8'h0);
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_status_unit.md
Name: flag_status_unit

Overview:
- Consumer end of the ALU flag interface: registers the 4-bit ALU flags (Z=bit0, C=bit1, V=bit2, N=bit3) into the processor status register.
- Evaluates branch condition codes against those flags and returns a registered taken/not-taken decision to the control unit.
- Provides a small LIFO for saving and restoring the flags across interrupt entry and return.
- Sits between the ALU and the control/branch logic in the datapath.

Parameters:
- STACK_DEPTH, 4, number of flag save entries (>=1).
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the StackDepth output.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- AluFlags  input  4  flags from the ALU {N,V,C,Z}.
- FlagsEn  input  1  load AluFlags into the status register this cycle.
- FlagsPush  input  1  save the status register onto the stack.
- FlagsPop  input  1  restore the status register from the stack top.
- ErrClear  input  1  clear StackErr.
- CondCode  input  4  branch condition selector.
- CondValid  input  1  evaluate CondCode this cycle.
- Flags  output  4  registered status flags.
- BranchValid  output  1  one-cycle pulse; BranchTaken is meaningful.
- BranchTaken  output  1  registered condition result.
- StackDepth  output  DEPTH_W  number of occupied stack entries.
- StackErr  output  1  sticky overflow/underflow/conflict error.

Behaviour:
- Reset (async, any time, including mid push/pop or evaluation): Flags=0, StackDepth=0, stack contents don't-care, BranchValid=0, BranchTaken=0, StackErr=0.
- Status register next-state, in priority order:
  - Valid pop: Flags <= stack top.
  - Else FlagsEn: Flags <= AluFlags.
  - Else hold.
- Push (FlagsPush=1, FlagsPop=0, StackDepth<STACK_DEPTH):
  - Writes the current (pre-edge) Flags at index StackDepth; StackDepth increments.
  - Push with FlagsEn in the same cycle saves the old value while Flags takes AluFlags.
- Pop (FlagsPop=1, FlagsPush=0, StackDepth>0):
  - Flags <= entry StackDepth-1; StackDepth decrements.
  - Pop overrides a same-cycle FlagsEn.
- Error cases (StackErr <= 1, sticky; no change to stack or depth):
  - Push when full: Flags follows FlagsEn.
  - Pop when empty: Flags follows FlagsEn.
  - FlagsPush and FlagsPop both high: Flags follows FlagsEn.
- StackErr clears on ErrClear=1 only if no new error occurs in the same cycle; a new error wins.
- Condition evaluation:
  - Latency 1: CondValid at edge k gives BranchValid=1 and BranchTaken after edge k, held for one cycle.
  - BranchValid=0 otherwise; BranchTaken holds its last value when BranchValid=0.
  - Evaluation uses the forwarded flags F, i.e. the value Flags will take at that same edge (pop/FlagsEn applied), so a compare followed by a branch in the same cycle sees fresh flags.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- Back-to-back CondValid produces back-to-back BranchValid pulses, one result per cycle, with no stall.

Test Plan:
- Reset released, FlagsEn=1 AluFlags=4'b0001, CondValid=1 CondCode=0 in the same cycle -> next cycle Flags=0001, BranchValid=1, BranchTaken=1; CondCode=1 the following cycle -> BranchTaken=0.
- Flags=4'b1000 (N only), evaluate codes 10,11,12,13 on consecutive cycles -> BranchTaken 0,1,0,1 with BranchValid high four cycles.
- STACK_DEPTH=4: push four times with Flags loaded 1,2,3,4 before each push; fifth push -> StackDepth=4, StackErr=1; four pops restore Flags 4,3,2,1, StackDepth ends at 0.
- Pop when empty with FlagsEn=1 AluFlags=4'b0110 -> Flags=0110, StackErr=1; ErrClear=1 next cycle -> StackErr=0.
- Flags=0010 pushed, then Pop with FlagsEn=1 AluFlags=1111 and CondValid CondCode=2 -> Flags=0010, BranchTaken=1 (pop wins and is forwarded).
- Assert Reset asynchronously mid-sequence with StackDepth=2, BranchValid=1 -> all outputs 0 immediately without waiting for a clock edge.
